hybrid_reducer: RTL and testbench
=================================

// Module: hybrid_reducer
// PURPOSE
//  Parametrised parallel+sequential sum reducer with valid/ready streaming.
//  - Each accepted beat: LANES words summed by a combinational adder tree.
//  - DEPTH consecutive beat-sums accumulated into one result word.
//  - Result held in an output register until the consumer takes it.
//  - Sits between a multi-lane pixel/sample source and a single-word consumer.
// PARAMETERS
//  WIDTH  16  bits per lane word, accumulator and result (unsigned)
//  LANES  2   input lanes per beat; power of 2, >=1
//  DEPTH  4   beats per result, >=1; CNT_W = max(1,$clog2(DEPTH))
// PORTS
//  real_clk   in   1            clock, rising edge
//  real_rst   in   1            async reset, active-high
//  flush      in   1            sync: drop partial accumulation
//  in_valid   in   1            input beat valid
//  in_ready   out  1            block can accept beat
//  in_data    in   LANES*WIDTH  lane k = in_data[k*WIDTH +: WIDTH]
//  out_valid  out  1            result valid
//  out_ready  in   1            consumer accepts result
//  out_data   out  WIDTH        reduced result
//  out_sat    out  1            result saturated (see CONFIGURATION)
//  beat_cnt   out  CNT_W        beats accumulated toward current result
// BEHAVIOUR
//  - Reset (async assert, sync release): out_valid=0, out_data=0, out_sat=0,
//    beat_cnt=0, acc=0. in_ready=1 out of reset.
//  - in_ready = !out_valid | out_ready (comb). Accept = in_valid & in_ready.
//  - Output hand-off = out_valid & out_ready; out_valid clears on that edge
//    unless a final beat is accepted on the same edge (then stays 1 with new data).
//  - beat_sum = sum of LANES words, mod 2^WIDTH (carries above WIDTH dropped).
//  - On accept with beat_cnt==0: acc <= beat_sum; else acc <= acc + beat_sum.
//  - beat_cnt increments per accept; on accept with beat_cnt==DEPTH-1 (final):
//    out_data <= acc_next, out_valid <= 1, beat_cnt <= 0.
//  - Latency: result visible one cycle after final-beat accept edge.
//  - DEPTH==1: every accepted beat is final; throughput one result/cycle
//    while out_ready=1.
//  - Backpressure: out_valid=1 & out_ready=0 -> in_ready=0; acc/beat_cnt frozen;
//    out_data stable.
//  - flush=1: beat_cnt<=0, acc<=0; any beat presented that cycle is dropped
//    (in_ready still reported; beat not counted). Does not touch the
//    out_valid/out_data pending result.
//  - Reset mid-accumulation or mid-output: partial sum and pending result lost.
//  - No X on outputs after reset regardless of in_data.
// CONFIGURATION
//  HYBRID_REDUCER_SAT_EN defined:
//    - All adds (tree and accumulate) saturate at 2^WIDTH-1.
//    - out_sat = 1 with a result if any add for that result clipped.
//    - out_sat is registered alongside out_data.
//  Not defined:
//    - Modular wrap-around arithmetic; out_sat tied 0.
// TESTING
//  1. Reset, LANES=2, DEPTH=4, beats {1,2},{3,4},{5,6},{7,8}, out_ready=1
//     -> out_data=36, out_valid 1 cycle after 4th accept, out_sat=0.
//  2. Same beats, out_ready=0 for 5 cycles after result -> in_ready=0,
//     out_data holds 36; next result accepted only after hand-off.
//  3. Two beats then flush=1 with in_valid=1, then 4 beats of {1,1}
//     -> out_data=8; the flushed-cycle beat not counted.
//  4. Overflow: 4 beats {0xFFFF,0x0001}, no macro -> out_data=0x0000,
//     out_sat=0; with HYBRID_REDUCER_SAT_EN -> 0xFFFF, out_sat=1.
//  5. DEPTH=1, in_valid=1 and out_ready=1 every cycle, beats {n,n}
//     -> one result per cycle, out_data=2n, in_ready never drops.
//  6. Assert real_rst with beat_cnt=2 and out_valid=1 -> all outputs 0
//     immediately; next 4 beats produce fresh correct sum.

Source files
------------

// File: rtl/hybrid_reducer.sv
// Multi-lane sum reducer: adder tree per beat, DEPTH beats accumulated into one held result.
// Define HYBRID_REDUCER_SAT_EN for saturating arithmetic with a registered out_sat flag.
module hybrid_reducer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LANES = 2,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   real_clk,
    input  logic                   real_rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_sat,
    output logic [CNT_W-1:0]       beat_cnt
);

`ifdef HYBRID_REDUCER_SAT_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEPTH - 1);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             part_sat_q, part_sat_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_sat_q, out_sat_d;

    // Heap-ordered tree: leaves at LANES..2*LANES-1, root at index 1.
    logic [WIDTH-1:0] node [1:2*LANES-1];
    logic             clip [1:2*LANES-1];
    logic [WIDTH:0]   tree_ext;

    logic [WIDTH-1:0] beat_sum;
    logic             beat_clip;
    logic [WIDTH-1:0] acc_base;
    logic [WIDTH:0]   acc_ext;
    logic [WIDTH-1:0] acc_next;
    logic             sat_next;
    logic             accept;
    logic             last_beat;

    always_comb begin
        tree_ext = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            node[int'(LANES) + k] = in_data[k*WIDTH +: WIDTH];
            clip[int'(LANES) + k] = 1'b0;
        end
        for (int i = int'(LANES) - 1; i >= 1; i--) begin
            tree_ext = {1'b0, node[2*i]} + {1'b0, node[2*i+1]};
            node[i]  = (SatEn && tree_ext[WIDTH]) ? '1 : tree_ext[WIDTH-1:0];
            clip[i]  = clip[2*i] | clip[2*i+1] | (SatEn && tree_ext[WIDTH]);
        end
    end

    assign beat_sum  = node[1];
    assign beat_clip = clip[1];

    // A new result starts from zero, so the first beat overwrites rather than adds.
    always_comb begin
        acc_base = (cnt_q == '0) ? '0 : acc_q;
        acc_ext  = {1'b0, acc_base} + {1'b0, beat_sum};
        acc_next = (SatEn && acc_ext[WIDTH]) ? '1 : acc_ext[WIDTH-1:0];
        sat_next = ((cnt_q == '0) ? 1'b0 : part_sat_q) | beat_clip
                   | (SatEn && acc_ext[WIDTH]);
    end

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready && !flush;
    assign last_beat = accept && (cnt_q == CntLast);

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        part_sat_d  = part_sat_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (flush) begin
            acc_d      = '0;
            cnt_d      = '0;
            part_sat_d = 1'b0;
        end else if (accept) begin
            acc_d      = acc_next;
            part_sat_d = sat_next;
            if (last_beat) begin
                cnt_d       = '0;
                out_valid_d = 1'b1;
                out_data_d  = acc_next;
                out_sat_d   = sat_next;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge real_clk or posedge real_rst) begin
        if (real_rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            part_sat_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            part_sat_q  <= part_sat_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_hybrid_reducer.sv
// Scoreboard bench for hybrid_reducer: a DEPTH=4 instance and a DEPTH=1 instance.
module tb_hybrid_reducer;
    localparam int W = 16;

    logic          real_clk = 1'b0;
    logic          real_rst = 1'b1;
    logic          flush    = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [2*W-1:0] in_data = '0;
    logic          in_ready, out_valid, out_sat;
    logic [W-1:0]  out_data;
    logic [1:0]    beat_cnt;

    logic          flush1 = 1'b0;
    logic          in_valid1 = 1'b0;
    logic          out_ready1 = 1'b1;
    logic [2*W-1:0] in_data1 = '0;
    logic          in_ready1, out_valid1, out_sat1;
    logic [W-1:0]  out_data1;
    logic [0:0]    beat_cnt1;

    hybrid_reducer #(.WIDTH(W), .LANES(2), .DEPTH(4)) dut (
        .real_clk(real_clk), .real_rst(real_rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .beat_cnt(beat_cnt)
    );

    hybrid_reducer #(.WIDTH(W), .LANES(2), .DEPTH(1)) dut1 (
        .real_clk(real_clk), .real_rst(real_rst), .flush(flush1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_sat(out_sat1), .beat_cnt(beat_cnt1)
    );

    always #5 real_clk = ~real_clk;

    int vecs = 0;
    int errs = 0;
    logic [W:0] exp_q [$];
    logic [W:0] exp1_q [$];
    logic [W:0] m_e, m_e1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitors: a hand-off happens on the posedge following a negedge with valid & ready.
    always @(negedge real_clk) begin
        if (!real_rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL unexpected result: got %0h, expected none", out_data);
            end else begin
                m_e = exp_q.pop_front();
                check("result data", 32'(out_data), 32'(m_e[W-1:0]));
                check("result sat", 32'(out_sat), 32'(m_e[W]));
            end
        end
    end

    always @(negedge real_clk) begin
        if (!real_rst && out_valid1 && out_ready1) begin
            if (exp1_q.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL unexpected d1 result: got %0h, expected none", out_data1);
            end else begin
                m_e1 = exp1_q.pop_front();
                check("d1 result data", 32'(out_data1), 32'(m_e1[W-1:0]));
                check("d1 result sat", 32'(out_sat1), 32'(m_e1[W]));
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = {b, a};
        @(negedge real_clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge real_clk);
        end
        if (!in_ready) begin
            vecs++;
            errs++;
            $display("FAIL send timeout: in_ready %0b, expected 1", in_ready);
        end
        @(posedge real_clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge real_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t, expected completion", $time);
        $fatal(1);
    end

    initial begin
        int n;
        repeat (2) tick();
        check("reset out_valid", 32'(out_valid), 0);
        check("reset out_data", 32'(out_data), 0);
        check("reset out_sat", 32'(out_sat), 0);
        check("reset beat_cnt", 32'(beat_cnt), 0);
        real_rst = 1'b0;
        tick();
        check("post-reset in_ready", 32'(in_ready), 1);

        // Basic 4-beat reduction
        exp_q.push_back({1'b0, 16'd36});
        send(1, 2);
        send(3, 4);
        check("beat_cnt after 2", 32'(beat_cnt), 2);
        send(5, 6);
        check("no early valid", 32'(out_valid), 0);
        send(7, 8);
        check("latency valid", 32'(out_valid), 1);
        check("latency data", 32'(out_data), 36);
        tick();
        check("valid cleared", 32'(out_valid), 0);

        // Backpressure holds result and blocks input
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 16'd36});
        exp_q.push_back({1'b0, 16'd10});
        send(1, 2);
        send(3, 4);
        send(5, 6);
        send(7, 8);
        in_valid = 1'b1;
        in_data  = {16'd0, 16'd10};
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall in_ready", 32'(in_ready), 0);
            check("stall out_data", 32'(out_data), 36);
            check("stall beat_cnt", 32'(beat_cnt), 0);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("post-handoff beat_cnt", 32'(beat_cnt), 1);
        check("post-handoff valid", 32'(out_valid), 0);
        send(0, 0);
        send(0, 0);
        send(0, 0);
        tick();

        // Flush drops partial sum and the beat presented that cycle
        exp_q.push_back({1'b0, 16'd8});
        send(5, 5);
        send(5, 5);
        check("pre-flush beat_cnt", 32'(beat_cnt), 2);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = {16'd7, 16'd7};
        check("flush in_ready", 32'(in_ready), 1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("post-flush beat_cnt", 32'(beat_cnt), 0);
        repeat (4) send(1, 1);
        tick();

        // Overflow
`ifdef HYBRID_REDUCER_SAT_EN
        exp_q.push_back({1'b1, 16'hFFFF});
`else
        exp_q.push_back({1'b0, 16'h0000});
`endif
        repeat (4) send(16'hFFFF, 16'h0001);
        tick();

        // DEPTH=1 streaming, one result per cycle
        for (int k = 1; k <= 8; k++) begin
            in_valid1 = 1'b1;
            in_data1  = {16'(k), 16'(k)};
            exp1_q.push_back({1'b0, 16'(2 * k)});
            check("d1 in_ready", 32'(in_ready1), 1);
            if (k > 1) begin
                check("d1 streaming valid", 32'(out_valid1), 1);
                check("d1 streaming data", 32'(out_data1), 32'(2 * (k - 1)));
            end
            tick();
        end
        in_valid1 = 1'b0;
        check("d1 last data", 32'(out_data1), 16);
        tick();
        check("d1 drained", 32'(out_valid1), 0);

        // Reset mid-accumulation
        send(9, 9);
        send(9, 9);
        check("pre-reset beat_cnt", 32'(beat_cnt), 2);
        real_rst = 1'b1;
        #1;
        check("async reset beat_cnt", 32'(beat_cnt), 0);
        check("async reset valid", 32'(out_valid), 0);
        tick();
        real_rst = 1'b0;
        exp_q.push_back({1'b0, 16'd20});
        repeat (4) send(2, 3);
        tick();

        // Reset with a pending result
        out_ready = 1'b0;
        repeat (4) send(4, 4);
        check("pending valid", 32'(out_valid), 1);
        check("pending data", 32'(out_data), 32);
        real_rst = 1'b1;
        #1;
        check("reset drops valid", 32'(out_valid), 0);
        check("reset drops data", 32'(out_data), 0);
        check("reset drops sat", 32'(out_sat), 0);
        check("reset in_ready", 32'(in_ready), 1);
        tick();
        real_rst  = 1'b0;
        out_ready = 1'b1;
        exp_q.push_back({1'b0, 16'd20});
        repeat (4) send(2, 3);

        n = 0;
        while ((exp_q.size() != 0 || exp1_q.size() != 0) && n < 20) begin
            tick();
            n++;
        end
        check("scoreboard drained", 32'(exp_q.size() + exp1_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
